// File: rtl/intr_dispatcher.sv
// intr_dispatcher: picks one pending interrupt source and presents it to the CPU.
// It then runs a claim/complete handshake and returns a one-cycle one-hot ack
// to the interrupt controller. A claim timeout abandons unserviced requests.
// Optional build macro INTR_DISPATCH_RR_EN selects round-robin arbitration.
// Without it, arbitration is fixed priority with the lowest index first.
module intr_dispatcher #(
    parameter int INTR_WIDTH    = 8,
    parameter int ID_WIDTH      = $clog2(INTR_WIDTH),
    parameter int CLAIM_TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [INTR_WIDTH-1:0] intr_pending_i,
    output logic [INTR_WIDTH-1:0] intr_ack_o,
    output logic                  cpu_irq_o,
    output logic [ID_WIDTH-1:0]   cpu_irq_id_o,
    input  logic                  cpu_claim_i,
    input  logic                  cpu_complete_i,
    input  logic [ID_WIDTH-1:0]   cpu_complete_id_i,
    output logic                  busy_o,
    output logic                  timeout_err_o,
    input  logic                  err_clear_i
);

    // The counter only has to reach CLAIM_TIMEOUT-1 before the state is left.
    localparam int CNT_W = (CLAIM_TIMEOUT < 2) ? 1 : $clog2(CLAIM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLAIM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_SERVICE = 2'd2,
        S_ACK     = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic                    mask_q, mask_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic                    irq_q;
    logic [ID_WIDTH-1:0]     irq_id_q;
    logic [INTR_WIDTH-1:0]   ack_q, ack_d;
    logic                    busy_q;

    logic [INTR_WIDTH-1:0]   masked_pending;
    logic                    win_valid;
    logic [ID_WIDTH-1:0]     win_id;

`ifdef INTR_DISPATCH_RR_EN
    logic [ID_WIDTH-1:0]     rr_q, rr_d;
    logic [ID_WIDTH:0]       rr_sum;
    logic [ID_WIDTH-1:0]     rr_idx;

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        return (id == ID_WIDTH'(INTR_WIDTH - 1)) ? '0 : id + 1'b1;
    endfunction
`endif

    // The source just acknowledged is hidden for one IDLE cycle.
    // This gives the controller time to drop its pending bit.
    for (genvar gi = 0; gi < INTR_WIDTH; gi++) begin : g_mask
        assign masked_pending[gi] = intr_pending_i[gi] &
                                    ~(mask_q && (id_q == ID_WIDTH'(gi)));
    end

`ifdef INTR_DISPATCH_RR_EN
    // Round-robin search: the first pending source at or after rr_q wins.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int i = 0; i < INTR_WIDTH; i++) begin
            rr_sum = {1'b0, rr_q} + (ID_WIDTH+1)'(i);
            if (rr_sum >= (ID_WIDTH+1)'(INTR_WIDTH)) begin
                rr_sum = rr_sum - (ID_WIDTH+1)'(INTR_WIDTH);
            end
            rr_idx = rr_sum[ID_WIDTH-1:0];
            if (!win_valid && masked_pending[rr_idx]) begin
                win_valid = 1'b1;
                win_id    = rr_idx;
            end
        end
    end
`else
    // Fixed priority: scan downward so the lowest set index is the last write.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int i = INTR_WIDTH - 1; i >= 0; i--) begin
            if (masked_pending[i]) begin
                win_valid = 1'b1;
                win_id    = ID_WIDTH'(i);
            end
        end
    end
`endif

    // Next-state logic for the handshake sequencer and its bookkeeping.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef INTR_DISPATCH_RR_EN
        rr_d    = rr_q;
`endif
        // Any expiry below overrides a clear in the same cycle.
        if (err_clear_i) begin
            err_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                mask_d = 1'b0;
                if (win_valid) begin
                    id_d    = win_id;
                    cnt_d   = '0;
                    state_d = S_PRESENT;
`ifdef INTR_DISPATCH_RR_EN
                    rr_d    = next_id(win_id);
`endif
                end
            end
            S_PRESENT: begin
                if (cpu_claim_i) begin
                    state_d = S_SERVICE;
                end else if (!intr_pending_i[id_q]) begin
                    state_d = S_IDLE;
                end else if ((CLAIM_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
`ifdef INTR_DISPATCH_RR_EN
                    rr_d    = next_id(id_q);
`endif
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SERVICE: begin
                if (cpu_complete_i && (cpu_complete_id_i == id_q)) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                mask_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The ack is decoded from the next state, so the registered pulse
    // lines up exactly with the ACK state.
    for (genvar gi = 0; gi < INTR_WIDTH; gi++) begin : g_ack
        assign ack_d[gi] = (state_d == S_ACK) && (id_d == ID_WIDTH'(gi));
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            mask_q   <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            irq_q    <= (state_d == S_PRESENT);
            irq_id_q <= id_d;
            ack_q    <= ack_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

`ifdef INTR_DISPATCH_RR_EN
    // Round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign intr_ack_o    = ack_q;
    assign cpu_irq_o     = irq_q;
    assign cpu_irq_id_o  = irq_id_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = err_q;

endmodule
